data_sram_like_adapter: RTL and testbench
=========================================

# data_sram_like_adapter

Converts the CPU's single-cycle data SRAM port (`data_sram_en/wen/addr/wdata/rdata`) into a handshaked SRAM-like bus (`req/addr_ok/data_ok`) and stalls the pipeline while a transaction is outstanding. It sits directly downstream of the CPU top's data port, between the memory stage and the data-side bus or cache.

## Interface
Parameters:
- none; widths are fixed at 32-bit address and data.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `data_sram_en`  in  1  memory-stage access request. Already masked by the CPU for exceptions.
- `data_sram_wen`  in  4  byte write enables; 0000 means read.
- `data_sram_addr`  in  32  physical address, word-aligned by the CPU.
- `data_sram_wdata`  in  32  store data, already byte-replicated.
- `data_sram_rdata`  out  32  load data returned to the CPU.
- `mem_advance`  in  1  the memory stage moves on this cycle.
- `stall`  out  1  freezes the pipeline.
- `req`  out  1  bus request.
- `wr`  out  1  1 = write.
- `size`  out  2  0 = byte, 1 = half, 2 = word.
- `addr`  out  32  bus address.
- `wdata`  out  32  bus write data.
- `addr_ok`  in  1  request accepted.
- `data_ok`  in  1  read data valid, or write complete.
- `rdata`  in  32  bus read data.

## Operation
- FSM has four states: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - `data_sram_en`=1: latch `wr`, `size`, `addr`, `wdata`; go to ADDR next cycle.
  - Otherwise stay in IDLE.
- **ADDR**
  - `req`=1; hold all latched fields stable.
  - `addr_ok`=1: go to DATA.
- **DATA**
  - `req`=0.
  - `data_ok`=1: capture `rdata` into the `data_sram_rdata` register; go to DONE.
  - For writes, the captured value is don't-care.
- **DONE**
  - Transaction is complete; the adapter holds it and waits for the pipeline.
  - `mem_advance`=1: go to IDLE.
  - Otherwise stay in DONE; the still-present `data_sram_en` must **not** re-issue the request.
- **Stall**
  - `stall` = (IDLE & `data_sram_en`) | ADDR | DATA.
  - `stall` = 0 in DONE.
- **wen decode** to `size` and `addr[1:0]`:
  - 0000 → read, size 2, low bits 00.
  - 1111 → size 2, 00.
  - 0011 → size 1, 00.
  - 1100 → size 1, 10.
  - 0001 → size 0, 00.
  - 0010 → size 0, 01.
  - 0100 → size 0, 10.
  - 1000 → size 0, 11.
  - Any other pattern → size 2, 00, write.
- `addr[31:2]` = `data_sram_addr[31:2]`.
- `wr` = |`data_sram_wen`.

## Timing
- Reset values: state IDLE; `req`, `wr`, `size`, `addr`, `wdata`, `data_sram_rdata` all 0. `stall` is then driven only by `data_sram_en`.
- `rst` during ADDR or DATA: return to IDLE immediately and drop the transaction. The bus must be reset by the same `rst`.
- Bus rules:
  - `data_ok` is never asserted in the same cycle as `addr_ok`; the earliest is one cycle later.
  - The adapter ignores `data_ok` outside DATA.
- Minimum latency, `data_sram_en` rising to `stall` low:
  - 1 cycle IDLE, then 1 cycle ADDR with immediate `addr_ok`, then 1 cycle DATA with immediate `data_ok`.
  - DONE is reached 3 cycles after the request.
- `data_sram_rdata` is stable from DONE entry until the next DATA capture.
- Back-to-back accesses: DONE & `mem_advance` → IDLE. A new `data_sram_en` in IDLE is latched the following cycle, so there is at least 1 idle bus cycle between transactions.
- `data_sram_en` dropping while in ADDR or DATA (a flush) does not abort: the transaction completes, and DONE waits for `mem_advance`.
- Only one transaction is outstanding at a time.

## Structure
- The shared package (`defines.vh` style) holds:
  - state encodings `ST_IDLE`, `ST_ADDR`, `ST_DATA`, `ST_DONE`.
  - size constants `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2.
- One combinational sub-module, `sram_wen_decode`: takes `wen` and produces `size`, `addr_lo` and `wr`.
- The top level holds the FSM and the latch registers.

## Test plan
- **Word read**: en=1, wen=0000, addr=0x1FC0_0010; `addr_ok` 2 cycles after `req`, `data_ok` 3 cycles later with rdata=0xDEAD_BEEF.
  - `req` high for exactly 3 cycles, `size`=2, `wr`=0.
  - `stall` high for 7 cycles, then `data_sram_rdata`=0xDEAD_BEEF.
- **Byte store**: wen=0100, addr=0x0000_1000, wdata=0x5A5A_5A5A, `addr_ok`/`data_ok` immediate.
  - `addr`=0x0000_1002, `size`=0, `wr`=1, `wdata`=0x5A5A_5A5A.
  - `stall` low after 3 cycles.
- **Half store**: wen=1100 → `addr[1:0]`=10, `size`=1.
- **Hold in DONE**: `mem_advance`=0 for 5 cycles with en still high → no second `req`, `stall`=0 throughout. Then `mem_advance`=1 plus a new en → a new `req` exactly 2 cycles later.
- **Reset mid-DATA**: `rst` pulsed in DATA → state IDLE and `req`=0 in the same cycle; a stale `data_ok` after reset is ignored and does not change `data_sram_rdata`.
- **Flush during ADDR**: en drops, `addr_ok` arrives → the transaction completes, DONE is reached, and `stall` stays 0 until `mem_advance`.

Source files
------------

// File: rtl/data_sram_like_adapter_pkg.sv
// ============================================================================
//  Module  : data_sram_like_adapter_pkg
//  Brief   : Shared state encodings and bus size codes for the SRAM-like adapter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package data_sram_like_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/data_sram_like_adapter_wen_decode.sv
// ============================================================================
//  Module  : sram_wen_decode
//  Brief   : Maps CPU byte enables to bus transfer size, low address bits and direction.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_wen_decode
    import data_sram_like_adapter_pkg::*;
(
    input  logic [3:0] wen_i,
    output logic [1:0] size_o,
    output logic [1:0] addr_lo_o,
    output logic       wr_o
);

    // Unrecognised enable patterns fall back to a full-word write.
    always_comb begin
        size_o    = SZ_WORD;
        addr_lo_o = 2'b00;
        case (wen_i)
            4'b0011: begin size_o = SZ_HALF; addr_lo_o = 2'b00; end
            4'b1100: begin size_o = SZ_HALF; addr_lo_o = 2'b10; end
            4'b0001: begin size_o = SZ_BYTE; addr_lo_o = 2'b00; end
            4'b0010: begin size_o = SZ_BYTE; addr_lo_o = 2'b01; end
            4'b0100: begin size_o = SZ_BYTE; addr_lo_o = 2'b10; end
            4'b1000: begin size_o = SZ_BYTE; addr_lo_o = 2'b11; end
            default: begin size_o = SZ_WORD; addr_lo_o = 2'b00; end
        endcase
    end

    assign wr_o = |wen_i;

endmodule

`default_nettype wire

// File: rtl/data_sram_like_adapter.sv
// ============================================================================
//  Module  : data_sram_like_adapter
//  Brief   : Turns the single-cycle CPU data SRAM port into a req/addr_ok/data_ok bus.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module data_sram_like_adapter
    import data_sram_like_adapter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        mem_advance,
    output logic        stall,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    state_e      state_q;
    logic        req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  w_dec_size;
    logic [1:0]  w_dec_lo;
    logic        w_dec_wr;

    // The CPU word-aligns its address; the low bits come from the enables instead.
    logic        unused_addr_lo;
    assign unused_addr_lo = ^data_sram_addr[1:0];

    sram_wen_decode u_wen_decode (
        .wen_i     (data_sram_wen),
        .size_o    (w_dec_size),
        .addr_lo_o (w_dec_lo),
        .wr_o      (w_dec_wr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_sram_en) begin
                        state_q <= ST_ADDR;
                        req_q   <= 1'b1;
                        wr_q    <= w_dec_wr;
                        size_q  <= w_dec_size;
                        addr_q  <= {data_sram_addr[31:2], w_dec_lo};
                        wdata_q <= data_sram_wdata;
                    end
                end
                ST_ADDR: begin
                    if (addr_ok) begin
                        state_q <= ST_DATA;
                        req_q   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (data_ok) begin
                        state_q <= ST_DONE;
                        rdata_q <= rdata;
                    end
                end
                // A lingering data_sram_en here belongs to the finished access.
                ST_DONE: begin
                    if (mem_advance) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall = ((state_q == ST_IDLE) && data_sram_en) ||
                   (state_q == ST_ADDR) || (state_q == ST_DATA);

    assign req             = req_q;
    assign wr              = wr_q;
    assign size            = size_q;
    assign addr            = addr_q;
    assign wdata           = wdata_q;
    assign data_sram_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_like_adapter.sv
// ============================================================================
//  Module  : tb_data_sram_like_adapter
//  Brief   : Self-checking bench for data_sram_like_adapter with a bus responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_sram_like_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'd0;
    logic [31:0] data_sram_addr = 32'd0;
    logic [31:0] data_sram_wdata = 32'd0;
    logic [31:0] data_sram_rdata;
    logic        mem_advance = 1'b0;
    logic        stall;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    data_sram_like_adapter dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .mem_advance     (mem_advance),
        .stall           (stall),
        .req             (req),
        .wr              (wr),
        .size            (size),
        .addr            (addr),
        .wdata           (wdata),
        .addr_ok         (addr_ok),
        .data_ok         (data_ok),
        .rdata           (rdata)
    );

    // Reference rule: one enabled byte -> byte at that lane, an aligned pair -> half,
    // everything else -> word at offset 0.
    function automatic void ref_decode(input logic [3:0] w, output logic [1:0] sz,
                                       output logic [1:0] lo);
        int ones;
        int first;
        ones  = 0;
        first = 0;
        for (int i = 3; i >= 0; i--) begin
            if (w[i]) begin
                ones++;
                first = i;
            end
        end
        sz = 2'd2;
        lo = 2'd0;
        if (ones == 1) begin
            sz = 2'd0;
            lo = first[1:0];
        end else if (ones == 2 && (w == 4'b0011 || w == 4'b1100)) begin
            sz = 2'd1;
            lo = first[1:0];
        end
    endfunction

    // One access: bus accepts on the (a_wait+1)th req cycle, returns data on the
    // d_wait-th cycle after acceptance. Expected stall = 1 + (a_wait+1) + d_wait.
    task automatic run_txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int a_wait, input int d_wait,
                           input bit flush);
        logic [1:0]  esz;
        logic [1:0]  elo;
        logic [31:0] eaddr;
        int stall_cnt;
        int req_cnt;
        int data_n;
        bit done;
        bit accepted;
        ref_decode(w, esz, elo);
        eaddr = {a[31:2], elo};
        @(negedge clk);
        data_sram_en    = 1'b1;
        data_sram_wen   = w;
        data_sram_addr  = a;
        data_sram_wdata = wd;
        mem_advance     = 1'b0;
        addr_ok         = 1'b0;
        data_ok         = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL idle_stall: got %b expected 1", stall); end
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b expected 0", req); end
        stall_cnt = 1;
        req_cnt   = 0;
        data_n    = 0;
        done      = 0;
        accepted  = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            addr_ok = 1'b0;
            data_ok = 1'b0;
            rdata   = $urandom;
            if (flush) data_sram_en = 1'b0;
            #1;
            if (!stall) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (req) begin
                    req_cnt++;
                    total++;
                    if (addr !== eaddr || size !== esz || wr !== (|w) || wdata !== wd) begin
                        bad++;
                        $display("FAIL bus_fields: got addr=%h size=%0d wr=%b wdata=%h expected addr=%h size=%0d wr=%b wdata=%h",
                                 addr, size, wr, wdata, eaddr, esz, |w, wd);
                    end
                    if (req_cnt == a_wait + 1) begin
                        addr_ok  = 1'b1;
                        accepted = 1;
                    end
                end else if (accepted) begin
                    data_n++;
                    if (data_n == d_wait) begin
                        data_ok = 1'b1;
                        rdata   = rd;
                    end
                end
            end
        end
        total++;
        if (!done) begin bad++; $display("FAIL txn_timeout: got stall=1 expected stall=0 within budget"); end
        total++;
        if (stall_cnt != 1 + (a_wait + 1) + d_wait) begin
            bad++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cnt, 1 + (a_wait + 1) + d_wait);
        end
        total++;
        if (req_cnt != a_wait + 1) begin
            bad++;
            $display("FAIL req_cycles: got %0d expected %0d", req_cnt, a_wait + 1);
        end
        exp_rdata = rd;
        if (w == 4'b0000) begin
            total++;
            if (data_sram_rdata !== rd) begin
                bad++;
                $display("FAIL load_data: got %h expected %h", data_sram_rdata, rd);
            end
        end
    endtask

    // Hold in DONE, then advance; keep_en leaves en asserted into the next IDLE.
    task automatic finish_txn(input int hold, input bit keep_en);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            data_ok = 1'b1;
            rdata   = $urandom;
            #1;
            total++;
            if (req !== 1'b0 || stall !== 1'b0 || data_sram_rdata !== exp_rdata) begin
                bad++;
                $display("FAIL done_hold: got req=%b stall=%b rdata=%h expected req=0 stall=0 rdata=%h",
                         req, stall, data_sram_rdata, exp_rdata);
            end
        end
        @(negedge clk);
        data_ok      = 1'b0;
        mem_advance  = 1'b1;
        data_sram_en = keep_en;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL advance_stall: got %b expected 0", stall); end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        data_sram_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req !== 1'b0 || wr !== 1'b0 || size !== 2'd0 || addr !== 32'd0 ||
            wdata !== 32'd0 || data_sram_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_values: got req=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h expected all 0",
                     req, wr, size, addr, wdata, data_sram_rdata);
        end
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_en: got %b expected 1", stall); end
        data_sram_en = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_noen: got %b expected 0", stall); end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'd0;
    endtask

    task automatic test_word_read();
        run_txn(4'b0000, 32'h1FC0_0010, 32'h1234_5678, 32'hDEAD_BEEF, 2, 3, 1'b0);
        finish_txn(1, 1'b0);
    endtask

    task automatic test_byte_store();
        run_txn(4'b0100, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0, 0, 1, 1'b0);
        finish_txn(0, 1'b0);
    endtask

    task automatic test_half_store();
        run_txn(4'b1100, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0, 1, 2, 1'b0);
        finish_txn(0, 1'b0);
    endtask

    task automatic test_hold_done_back_to_back();
        run_txn(4'b0000, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b0);
        finish_txn(5, 1'b1);
        run_txn(4'b0011, 32'h0000_3008, 32'h7777_7777, 32'h0, 0, 1, 1'b0);
        finish_txn(0, 1'b0);
    endtask

    task automatic test_flush();
        run_txn(4'b0000, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 1, 2, 1'b1);
        finish_txn(3, 1'b0);
    endtask

    task automatic test_reset_mid_data();
        @(negedge clk);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_5000;
        mem_advance    = 1'b0;
        @(negedge clk);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || req !== 1'b0) begin
            bad++;
            $display("FAIL in_data: got stall=%b req=%b expected stall=1 req=0", stall, req);
        end
        rst          = 1'b1;
        data_sram_en = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_data: got stall=%b req=%b expected stall=0 req=0", stall, req);
        end
        @(negedge clk);
        rst     = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'hFFFF_0000;
        @(negedge clk);
        data_ok = 1'b0;
        #1;
        total++;
        if (data_sram_rdata !== 32'd0 || stall !== 1'b0 || req !== 1'b0) begin
            bad++;
            $display("FAIL stale_data_ok: got rdata=%h stall=%b req=%b expected rdata=0 stall=0 req=0",
                     data_sram_rdata, stall, req);
        end
        exp_rdata = 32'd0;
    endtask

    task automatic test_random();
        logic [3:0] w;
        for (int n = 0; n < 25; n++) begin
            w = 4'($urandom_range(0, 15));
            run_txn(w, $urandom, $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            finish_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_store();
        test_half_store();
        test_hold_done_back_to_back();
        test_flush();
        test_reset_mid_data();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
